// File: rtl/iic_arb_pkg.sv
// Shared types and constants for the IIC EEPROM request arbiter.
// The one-hot helper is sized for the largest supported requester count.
package iic_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GAP
  } state_e;

  localparam int DEF_TIMEOUT_CYC = 100000;
  localparam int DEF_GAP_CYC     = 10;
  localparam int MAX_REQ         = 8;

  function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [2:0] idx);
    idx_to_onehot      = '0;
    idx_to_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/iic_req_arbiter_if.sv
// Requester and engine signals of the arbiter, bundled as one interface.
// The arbiter uses the slave modport; requesters and engine drive the master side.
interface iic_req_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DAT_W = 32,
  parameter int RD_W  = 8
);

  logic [N_REQ-1:0]       i_req;
  logic [N_REQ*DAT_W-1:0] i_cfg_dat;
  logic [N_REQ-1:0]       o_gnt;
  logic [N_REQ-1:0]       o_done;
  logic [N_REQ-1:0]       o_err;
  logic [RD_W-1:0]        o_rd_dat;
  logic [DAT_W-1:0]       o_cfg_dat;
  logic                   o_cfg_start_en;
  logic                   i_eng_busy;
  logic                   i_eng_done;
  logic                   i_eng_nack;
  logic [RD_W-1:0]        i_eng_rd_dat;

  modport master (
    output i_req, i_cfg_dat, i_eng_busy, i_eng_done, i_eng_nack, i_eng_rd_dat,
    input  o_gnt, o_done, o_err, o_rd_dat, o_cfg_dat, o_cfg_start_en
  );

  modport slave (
    input  i_req, i_cfg_dat, i_eng_busy, i_eng_done, i_eng_nack, i_eng_rd_dat,
    output o_gnt, o_done, o_err, o_rd_dat, o_cfg_dat, o_cfg_start_en
  );

endinterface

// File: rtl/iic_rr_pick.sv
// Combinational round-robin picker: first asserted request after ptr_i, wrapping.
module iic_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] win_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // The last requester served (ptr_i) is checked last, giving it lowest priority.
  always_comb begin
    cand  = '0;
    found = 1'b0;
    win_o = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % N_REQ);
      if (!found && req_i[cand]) begin
        win_o = cand;
        found = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/iic_req_arbiter.sv
// Shares one IIC EEPROM engine between N_REQ requesters: round-robin grant,
// one-cycle start pulse, wait for done or timeout, then a bus-free gap.
module iic_req_arbiter
  import iic_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DAT_W       = 32,
  parameter int RD_W        = 8,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC
) (
  input logic               sys_clk,
  input logic               rst,
  iic_req_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] err_q, err_d;
  logic [RD_W-1:0]  rd_q, rd_d;
  logic [DAT_W-1:0] cfg_q, cfg_d;
  logic             start_q, start_d;

  logic [IDX_W-1:0] pickIdx;
  logic             pickValid;
  logic [N_REQ-1:0] pickOneHot;
  logic [N_REQ-1:0] winOneHot;

  iic_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i   (bus.i_req),
    .ptr_i   (ptr_q),
    .win_o   (pickIdx),
    .valid_o (pickValid)
  );

  assign pickOneHot = N_REQ'(idx_to_onehot(3'(pickIdx)));
  assign winOneHot  = N_REQ'(idx_to_onehot(3'(win_q)));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    tcnt_d  = tcnt_q;
    gcnt_d  = gcnt_q;
    gnt_d   = gnt_q;
    cfg_d   = cfg_q;
    rd_d    = rd_q;
    done_d  = '0;
    err_d   = '0;
    start_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pickValid && !bus.i_eng_busy) begin
          win_d   = pickIdx;
          gnt_d   = pickOneHot;
          cfg_d   = bus.i_cfg_dat[int'(pickIdx)*DAT_W +: DAT_W];
          start_d = 1'b1;
          tcnt_d  = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Engine done takes precedence over a timeout landing in the same cycle.
        if (bus.i_eng_done) begin
          done_d  = winOneHot;
          err_d   = bus.i_eng_nack ? winOneHot : '0;
          rd_d    = bus.i_eng_rd_dat;
          gnt_d   = '0;
          ptr_d   = win_q;
          gcnt_d  = '0;
          state_d = GAP;
        end else if (tcnt_q == TO_LAST) begin
          done_d  = winOneHot;
          err_d   = winOneHot;
          gnt_d   = '0;
          ptr_d   = win_q;
          gcnt_d  = '0;
          state_d = GAP;
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (gcnt_q == GAP_LAST) begin
          if (!bus.i_eng_busy) state_d = IDLE;
        end else begin
          gcnt_d = gcnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(N_REQ - 1);
      win_q   <= '0;
      tcnt_q  <= '0;
      gcnt_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rd_q    <= '0;
      cfg_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      tcnt_q  <= tcnt_d;
      gcnt_q  <= gcnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      cfg_q   <= cfg_d;
      start_q <= start_d;
    end
  end

  assign bus.o_gnt          = gnt_q;
  assign bus.o_done         = done_q;
  assign bus.o_err          = err_q;
  assign bus.o_rd_dat       = rd_q;
  assign bus.o_cfg_dat      = cfg_q;
  assign bus.o_cfg_start_en = start_q;

endmodule
